// File: rtl/apb_uart_regif_if.sv
// APB3 completer-side bus bundle for the UART register interface.
// The requester drives the select/address/data signals; the completer returns the response.
interface apb_uart_regif_if #(
  parameter int ADDR_W = 12
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_uart_regif.sv
// Zero-wait-state APB3 register block feeding the UART serializers.
// It holds the TX/RX byte FIFOs, CTRL/STATUS, the sticky RX overrun flag and a registered irq.
module apb_uart_regif #(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  apb_uart_regif_if.slave  apb,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  output logic             irq_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    A_TXDATA = 3'd0,
    A_RXDATA = 3'd1,
    A_STATUS = 3'd2,
    A_CTRL   = 3'd3,
    A_CLEAR  = 3'd4
  } addr_e;

  logic [7:0]       tx_mem_q [FIFO_DEPTH];
  logic [7:0]       rx_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [PTR_W-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             ovr_q, ovr_d;
  logic             irq_q, irq_d;

  logic        access, wr_acc, rd_acc;
  logic [2:0]  sel;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push, tx_pop, rx_push, rx_pop, ovr_set, ovr_clr;
  logic [31:0] status;
  logic        unused_ok;

  assign unused_ok = ^{apb.PADDR[ADDR_W-1:5], apb.PADDR[1:0], apb.PWDATA[31:8]};

  assign access   = apb.PSEL & apb.PENABLE;
  assign wr_acc   = access & apb.PWRITE;
  assign rd_acc   = access & ~apb.PWRITE;
  assign sel      = apb.PADDR[4:2];

  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);

  assign tx_valid_o = ctrl_q[0] & ~tx_empty;
  assign tx_data_o  = tx_mem_q[tx_rd_q];
  assign irq_o      = irq_q;
  assign apb.PREADY = 1'b1;

  // Full/empty come from the pre-edge state, so a same-cycle pop never rescues a push into a full FIFO.
  assign tx_push = wr_acc & (sel == A_TXDATA) & ~tx_full;
  assign tx_pop  = tx_valid_o & tx_ready_i;
  assign rx_push = rx_valid_i & ctrl_q[1] & ~rx_full;
  assign ovr_set = rx_valid_i & ctrl_q[1] & rx_full;
  assign rx_pop  = rd_acc & (sel == A_RXDATA) & ~rx_empty;
  assign ovr_clr = wr_acc & (sel == A_CLEAR) & apb.PWDATA[4];

  always_comb begin
    status             = '0;
    status[0]          = tx_full;
    status[1]          = tx_empty;
    status[2]          = rx_full;
    status[3]          = rx_empty;
    status[4]          = ovr_q;
    status[8 +: CNT_W]  = tx_cnt_q;
    status[16 +: CNT_W] = rx_cnt_q;
  end

  always_comb begin
    apb.PRDATA  = '0;
    apb.PSLVERR = 1'b0;
    if (access && !rst_i) begin
      case (sel)
        A_TXDATA: apb.PSLVERR = apb.PWRITE & tx_full;
        A_RXDATA: begin
          if (!apb.PWRITE) begin
            if (rx_empty) apb.PSLVERR = 1'b1;
            else          apb.PRDATA  = {24'b0, rx_mem_q[rx_rd_q]};
          end
        end
        A_STATUS: if (!apb.PWRITE) apb.PRDATA = status;
        A_CTRL:   if (!apb.PWRITE) apb.PRDATA = {28'b0, ctrl_q};
        A_CLEAR:  apb.PRDATA = '0;
        default:  apb.PSLVERR = 1'b1;
      endcase
    end
  end

  always_comb begin
    tx_wr_d  = tx_push ? tx_wr_q + PTR_W'(1) : tx_wr_q;
    tx_rd_d  = tx_pop  ? tx_rd_q + PTR_W'(1) : tx_rd_q;
    rx_wr_d  = rx_push ? rx_wr_q + PTR_W'(1) : rx_wr_q;
    rx_rd_d  = rx_pop  ? rx_rd_q + PTR_W'(1) : rx_rd_q;
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + CNT_W'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - CNT_W'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + CNT_W'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - CNT_W'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
    ctrl_d = (wr_acc && sel == A_CTRL) ? apb.PWDATA[3:0] : ctrl_q;
    // A new overrun beats a same-cycle clear.
    ovr_d  = ovr_set ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);
    irq_d  = (ctrl_q[2] & tx_empty) | (ctrl_q[3] & ~rx_empty) | ovr_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      ctrl_q   <= '0;
      ovr_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      ctrl_q   <= ctrl_d;
      ovr_q    <= ovr_d;
      irq_q    <= irq_d;
    end
  end

  // Storage needs no reset; the pointers and counts define what is valid.
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= apb.PWDATA[7:0];
    if (rx_push) rx_mem_q[rx_wr_q] <= rx_data_i;
  end
endmodule
